mips_exec_core: RTL and testbench

// Two-stage MIPS integer execute core (D: decode/operand read, E: execute/writeback) fed by
// the opcode buffer over a valid/ready stream. Owns the 32-entry register file, resolves

---
 rtl/mips_exec_core_if.sv | 17 +
 rtl/mips_exec_core.sv | 227 ++++++++++++++++++++++
 tb/tb_mips_exec_core.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_exec_core_if.sv
`default_nettype none
// ============================================================================
// mips_exec_core_if : valid/ready instruction stream, opcode buffer -> core
// Revision: 1.0
// ============================================================================
interface mips_exec_core_if #(
  parameter int PC_WIDTH = 32
) ();
  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr_data;
  logic [PC_WIDTH-1:0] instr_pc;

  modport master (output instr_valid, instr_data, instr_pc, input  instr_ready);
  modport slave  (input  instr_valid, instr_data, instr_pc, output instr_ready);
endinterface
`default_nettype wire

// File: rtl/mips_exec_core.sv
`default_nettype none
// ============================================================================
// mips_exec_core : two-stage (decode / execute+writeback) MIPS integer core.
// Optional macro EXEC_BYPASS_EN forwards E results into D instead of stalling.
// Revision: 1.0
// ============================================================================
module mips_exec_core #(
  parameter int          PC_WIDTH  = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          CNT_WIDTH = 32
) (
  input  wire                  clk,
  input  wire                  reset,
  mips_exec_core_if.slave      instr_if,
  output logic                 redirect_vld,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 wb_valid,
  output logic [4:0]           wb_addr,
  output logic [31:0]          wb_data,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired,
  input  wire  [4:0]           dbg_raddr,
  output logic [31:0]          dbg_rdata
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                         OP_ORI   = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_ADD = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27, FN_SLT = 6'h2a,
                         FN_SLTU = 6'h2b;

  logic                 d_valid_q, d_valid_d;
  logic [31:0]          d_instr_q, d_instr_d;
  logic [PC_WIDTH-1:0]  d_pc_q, d_pc_d;
  logic                 e_valid_q, e_valid_d;
  logic [31:0]          e_instr_q, e_instr_d;
  logic [PC_WIDTH-1:0]  e_pc_q, e_pc_d;
  logic [31:0]          e_a_q, e_a_d, e_b_q, e_b_d;
  logic [31:0]          regs_q [32];
  logic [31:0]          regs_d [32];
  logic                 redirect_vld_q, redirect_vld_d;
  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [4:0]           wb_addr_q, wb_addr_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic [4:0]  d_rs, d_rt;
  logic [31:0] rf_a, rf_b, op_a, op_b;
  logic        stall, d_adv, flush, accept, instr_ready;

  logic [5:0]  e_op, e_funct;
  logic [4:0]  e_rt, e_rd, e_shamt;
  logic [31:0] e_simm, e_zimm, e_pc4;
  logic [31:0] e_result, e_target;
  logic [4:0]  e_dest;
  logic        e_writes, e_legal, e_taken, e_wen;

  // ---------------- execute -------------------------------------------------
  assign e_op    = e_instr_q[31:26];
  assign e_rt    = e_instr_q[20:16];
  assign e_rd    = e_instr_q[15:11];
  assign e_shamt = e_instr_q[10:6];
  assign e_funct = e_instr_q[5:0];
  assign e_simm  = {{16{e_instr_q[15]}}, e_instr_q[15:0]};
  assign e_zimm  = {16'h0, e_instr_q[15:0]};
  assign e_pc4   = 32'(e_pc_q) + 32'd4;

  always_comb begin
    e_result = 32'h0;
    e_dest   = 5'd0;
    e_writes = 1'b0;
    e_legal  = 1'b1;
    e_taken  = 1'b0;
    e_target = 32'h0;
    case (e_op)
      OP_RTYPE: begin
        e_dest   = e_rd;
        e_writes = 1'b1;
        case (e_funct)
          FN_SLL:          e_result = e_b_q << e_shamt;
          FN_SRL:          e_result = e_b_q >> e_shamt;
          FN_SRA:          e_result = $unsigned($signed(e_b_q) >>> e_shamt);
          FN_ADD, FN_ADDU: e_result = e_a_q + e_b_q;
          FN_SUB, FN_SUBU: e_result = e_a_q - e_b_q;
          FN_AND:          e_result = e_a_q & e_b_q;
          FN_OR:           e_result = e_a_q | e_b_q;
          FN_XOR:          e_result = e_a_q ^ e_b_q;
          FN_NOR:          e_result = ~(e_a_q | e_b_q);
          FN_SLT:          e_result = {31'h0, $signed(e_a_q) < $signed(e_b_q)};
          FN_SLTU:         e_result = {31'h0, e_a_q < e_b_q};
          default: begin
            e_legal  = 1'b0;
            e_writes = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin e_dest = e_rt; e_writes = 1'b1; e_result = e_a_q + e_simm; end
      OP_SLTI: begin
        e_dest = e_rt; e_writes = 1'b1;
        e_result = {31'h0, $signed(e_a_q) < $signed(e_simm)};
      end
      OP_ANDI: begin e_dest = e_rt; e_writes = 1'b1; e_result = e_a_q & e_zimm; end
      OP_ORI:  begin e_dest = e_rt; e_writes = 1'b1; e_result = e_a_q | e_zimm; end
      OP_XORI: begin e_dest = e_rt; e_writes = 1'b1; e_result = e_a_q ^ e_zimm; end
      OP_LUI:  begin e_dest = e_rt; e_writes = 1'b1; e_result = {e_instr_q[15:0], 16'h0}; end
      OP_J: begin
        e_taken  = 1'b1;
        e_target = {e_pc4[31:28], e_instr_q[25:0], 2'b00};
      end
      OP_BEQ: begin e_taken = (e_a_q == e_b_q); e_target = e_pc4 + {e_simm[29:0], 2'b00}; end
      OP_BNE: begin e_taken = (e_a_q != e_b_q); e_target = e_pc4 + {e_simm[29:0], 2'b00}; end
      default: e_legal = 1'b0;
    endcase
  end

  assign e_wen = e_valid_q & e_legal & e_writes & (e_dest != 5'd0);
  assign flush = e_valid_q & e_legal & e_taken;

  // ---------------- decode / operand read -----------------------------------
  assign d_rs = d_instr_q[25:21];
  assign d_rt = d_instr_q[20:16];
  assign rf_a = (d_rs == 5'd0) ? 32'h0 : regs_q[d_rs];
  assign rf_b = (d_rt == 5'd0) ? 32'h0 : regs_q[d_rt];

`ifdef EXEC_BYPASS_EN
  assign op_a  = (e_wen && (e_dest == d_rs)) ? e_result : rf_a;
  assign op_b  = (e_wen && (e_dest == d_rt)) ? e_result : rf_b;
  assign stall = 1'b0;
`else
  // Stalled D re-reads the regfile next cycle, after E's write has landed.
  assign op_a  = rf_a;
  assign op_b  = rf_b;
  assign stall = d_valid_q & e_wen & ((e_dest == d_rs) | (e_dest == d_rt));
`endif

  assign d_adv       = d_valid_q & ~stall;
  assign instr_ready = ~reset & ~redirect_vld_q & (~d_valid_q | d_adv);
  assign accept      = instr_if.instr_valid & instr_ready;

  // A taken branch squashes D, including a word accepted on the same edge.
  always_comb begin
    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (flush) begin
      d_valid_d = 1'b0;
    end else if (accept) begin
      d_valid_d = 1'b1;
      d_instr_d = instr_if.instr_data;
      d_pc_d    = instr_if.instr_pc;
    end else if (d_adv) begin
      d_valid_d = 1'b0;
    end
    e_valid_d = d_adv & ~flush;
    e_instr_d = d_adv ? d_instr_q : e_instr_q;
    e_pc_d    = d_adv ? d_pc_q    : e_pc_q;
    e_a_d     = d_adv ? op_a      : e_a_q;
    e_b_d     = d_adv ? op_b      : e_b_q;
  end

  // ---------------- writeback / status --------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (e_wen) regs_d[e_dest] = e_result;
    wb_valid_d     = e_wen;
    wb_addr_d      = e_wen ? e_dest : 5'd0;
    wb_data_d      = e_wen ? e_result : 32'h0;
    redirect_vld_d = flush;
    redirect_pc_d  = flush ? e_target[PC_WIDTH-1:0] : redirect_pc_q;
    illegal_d      = e_valid_q & ~e_legal;
    retired_d      = retired_q + CNT_WIDTH'(e_valid_q & e_legal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid_q      <= 1'b0;
      d_instr_q      <= 32'h0;
      d_pc_q         <= '0;
      e_valid_q      <= 1'b0;
      e_instr_q      <= 32'h0;
      e_pc_q         <= '0;
      e_a_q          <= 32'h0;
      e_b_q          <= 32'h0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= RESET_PC[PC_WIDTH-1:0];
      wb_valid_q     <= 1'b0;
      wb_addr_q      <= 5'd0;
      wb_data_q      <= 32'h0;
      illegal_q      <= 1'b0;
      retired_q      <= '0;
    end else begin
      d_valid_q      <= d_valid_d;
      d_instr_q      <= d_instr_d;
      d_pc_q         <= d_pc_d;
      e_valid_q      <= e_valid_d;
      e_instr_q      <= e_instr_d;
      e_pc_q         <= e_pc_d;
      e_a_q          <= e_a_d;
      e_b_q          <= e_b_d;
      regs_q         <= regs_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
      wb_valid_q     <= wb_valid_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      illegal_q      <= illegal_d;
      retired_q      <= retired_d;
    end
  end

  assign instr_if.instr_ready = instr_ready;
  assign redirect_vld = redirect_vld_q;
  assign redirect_pc  = redirect_pc_q;
  assign wb_valid     = wb_valid_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign illegal      = illegal_q;
  assign retired      = retired_q;
  assign dbg_rdata    = (dbg_raddr == 5'd0) ? 32'h0 : regs_q[dbg_raddr];

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_core.sv
`default_nettype none
// ============================================================================
// tb_mips_exec_core : directed + random stream against an ISA-level model.
// Revision: 1.0
// ============================================================================
module tb_mips_exec_core;
  localparam int PW = 32;
`ifdef EXEC_BYPASS_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_vld, wb_valid, illegal;
  logic [PW-1:0] redirect_pc;
  logic [4:0]  wb_addr, dbg_raddr;
  logic [31:0] wb_data, dbg_rdata, retired;

  mips_exec_core_if #(.PC_WIDTH(PW)) instr_if ();

  mips_exec_core #(.PC_WIDTH(PW), .RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr_if(instr_if),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .retired(retired),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural model: instructions execute in program order at acceptance.
  logic [31:0] mregs [32];
  logic [36:0] exp_wb [$];
  logic [31:0] exp_redir [$];
  int          pend_illegal, redirect_cnt, illegal_cnt;
  logic [31:0] model_retired, pc_r, last_redirect_pc;
  bit          wrong_path;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    exp_wb.delete();
    exp_redir.delete();
    pend_illegal = 0;
    model_retired = 0;
    wrong_path = 0;
  endtask

  task automatic model_exec(input logic [31:0] w, input logic [31:0] pc);
    logic [31:0] a, b, simm, zimm, res, pc4, tgt;
    logic [4:0]  dst;
    bit ok, wr, tk;
    if (wrong_path) return;
    a = mregs[w[25:21]];
    b = mregs[w[20:16]];
    simm = {{16{w[15]}}, w[15:0]};
    zimm = {16'h0, w[15:0]};
    pc4 = pc + 32'd4;
    ok = 1; wr = 1; tk = 0; res = 0; tgt = 0; dst = w[20:16];
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        case (w[5:0])
          6'h00: res = b << w[10:6];
          6'h02: res = b >> w[10:6];
          6'h03: res = $unsigned($signed(b) >>> w[10:6]);
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: res = (a < b) ? 32'd1 : 32'd0;
          default: ok = 0;
        endcase
      end
      6'h08, 6'h09: res = a + simm;
      6'h0a: res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
      6'h0c: res = a & zimm;
      6'h0d: res = a | zimm;
      6'h0e: res = a ^ zimm;
      6'h0f: res = zimm * 32'd65536;
      6'h02: begin wr = 0; tk = 1; tgt = {pc4[31:28], w[25:0], 2'b00}; end
      6'h04: begin wr = 0; tk = (a == b); tgt = pc4 + simm * 4; end
      6'h05: begin wr = 0; tk = (a != b); tgt = pc4 + simm * 4; end
      default: ok = 0;
    endcase
    if (!ok) begin
      pend_illegal++;
    end else begin
      model_retired++;
      if (wr && dst != 0) begin
        mregs[dst] = res;
        exp_wb.push_back({dst, res});
      end
      if (tk) begin
        exp_redir.push_back(tgt);
        wrong_path = 1;
      end
    end
  endtask

  task automatic monitor();
    logic [36:0] e;
    logic [31:0] t;
    if (reset) return;
    if (wb_valid) begin
      if (exp_wb.size() == 0) check("wb_unexpected", wb_valid, 0);
      else begin
        e = exp_wb.pop_front();
        check("wb_addr", wb_addr, e[36:32]);
        check("wb_data", wb_data, e[31:0]);
      end
    end
    if (redirect_vld) begin
      redirect_cnt++;
      last_redirect_pc = redirect_pc;
      if (exp_redir.size() == 0) check("redirect_unexpected", redirect_vld, 0);
      else begin
        t = exp_redir.pop_front();
        check("redirect_pc", redirect_pc, t);
        pc_r = t;
        wrong_path = 0;
      end
    end
    if (illegal) begin
      illegal_cnt++;
      check("illegal_expected", pend_illegal > 0, 1);
      if (pend_illegal > 0) pend_illegal--;
    end
  endtask

  task automatic tick(input bit have, input logic [31:0] word, output bit acc);
    @(negedge clk);
    monitor();
    instr_if.instr_valid = have;
    instr_if.instr_data  = word;
    instr_if.instr_pc    = pc_r[PW-1:0];
    acc = have && instr_if.instr_ready;
    if (acc) begin
      model_exec(word, pc_r);
      pc_r = pc_r + 32'd4;
    end
    @(posedge clk);
    #1;
    instr_if.instr_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, output int waits);
    bit acc = 0;
    waits = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      tick(1'b1, w, acc);
      if (!acc) waits++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_raddr = r;
    #1;
    v = dbg_rdata;
  endtask

  task automatic drain();
    bit acc;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, acc);
    check("wb_missing", exp_wb.size(), 0);
    check("redirect_missing", exp_redir.size(), 0);
    check("illegal_missing", pend_illegal, 0);
    check("retired", retired, model_retired);
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      check($sformatf("reg_r%0d", i), v, mregs[i]);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn, op;
    logic [15:0] off;
    k  = $urandom_range(0, 99);
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (k < 45) begin
      case ($urandom_range(0, 12))
        0: fn = 6'h00;  1: fn = 6'h02;  2: fn = 6'h03;  3: fn = 6'h20;  4: fn = 6'h21;
        5: fn = 6'h22;  6: fn = 6'h23;  7: fn = 6'h24;  8: fn = 6'h25;  9: fn = 6'h26;
        10: fn = 6'h27; 11: fn = 6'h2a; default: fn = 6'h2b;
      endcase
      return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
    end else if (k < 85) begin
      case ($urandom_range(0, 6))
        0: op = 6'h08; 1: op = 6'h09; 2: op = 6'h0a; 3: op = 6'h0c;
        4: op = 6'h0d; 5: op = 6'h0e; default: op = 6'h0f;
      endcase
      return itype(op, rs, rt, 16'($urandom));
    end else if (k < 91) begin
      off = 16'($urandom_range(0, 16)) - 16'd8;
      return itype(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, off);
    end else if (k < 94) begin
      return {6'h02, 26'($urandom)};
    end else begin
      case ($urandom_range(0, 2))
        0: return {6'h3f, 26'($urandom)};
        1: return {6'h00, 20'($urandom), 6'h3f};
        default: return itype(6'h0b, rs, rt, 16'($urandom));
      endcase
    end
  endfunction

  initial begin
    int waits, rc0, il0;
    logic [31:0] v, ret0, word;
    bit acc, pending;
    reset = 1'b1;
    instr_if.instr_valid = 1'b0;
    instr_if.instr_data  = 32'h0;
    instr_if.instr_pc    = '0;
    dbg_raddr = 5'd0;
    pc_r = 0; redirect_cnt = 0; illegal_cnt = 0; last_redirect_pc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_instr_ready", instr_if.instr_ready, 0);
    check("rst_redirect_vld", redirect_vld, 0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    read_reg(5'd5, v);
    check("rst_dbg_r5", v, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    send(itype(6'h08, 0, 1, 16'd5), waits);
    send(itype(6'h08, 0, 2, 16'd7), waits);
    send(rtype(1, 2, 3, 6'h20), waits);
    drain();
    read_reg(5'd3, v);
    check("t1_r3", v, 32'd12);
    check("t1_retired", retired, 32'd3);

    send(itype(6'h0d, 0, 4, 16'hffff), waits);
    send(itype(6'h08, 0, 5, 16'hffff), waits);
    send(itype(6'h0f, 0, 6, 16'h1234), waits);
    drain();
    read_reg(5'd4, v); check("t2_ori", v, 32'h0000ffff);
    read_reg(5'd5, v); check("t2_addi_neg", v, 32'hffffffff);
    read_reg(5'd6, v); check("t2_lui", v, 32'h12340000);

    send(itype(6'h08, 0, 1, 16'd1), waits);
    send(rtype(1, 1, 2, 6'h20), waits);
    send(32'h0, waits);
    check("t3_stall_cycles", waits, EXP_STALL);
    drain();
    read_reg(5'd2, v); check("t3_r2", v, 32'd2);

    pc_r = 32'h40;
    rc0 = redirect_cnt;
    send(itype(6'h04, 0, 0, 16'd3), waits);
    send(itype(6'h08, 0, 7, 16'h77), waits);
    drain();
    check("t4_beq_count", redirect_cnt - rc0, 1);
    check("t4_beq_target", last_redirect_pc, 32'h50);
    read_reg(5'd7, v); check("t4_wrongpath_r7", v, 0);
    rc0 = redirect_cnt;
    send(itype(6'h05, 0, 0, 16'd3), waits);
    send(itype(6'h08, 0, 8, 16'h88), waits);
    drain();
    check("t4_bne_no_redirect", redirect_cnt - rc0, 0);
    pc_r = 32'h8;
    send({6'h02, 26'h100}, waits);
    drain();
    check("t4_j_target", last_redirect_pc, 32'h400);

    il0 = illegal_cnt;
    ret0 = model_retired;
    send(32'hfc000000, waits);
    drain();
    check("t5_illegal_pulses", illegal_cnt - il0, 1);
    check("t5_retired_unchanged", retired, ret0);
    send(itype(6'h08, 0, 0, 16'd9), waits);
    drain();
    read_reg(5'd0, v); check("t5_r0", v, 0);

    send(itype(6'h08, 0, 9, 16'd99), waits);
    send(itype(6'h08, 0, 10, 16'd98), waits);
    reset = 1'b1;
    model_reset();
    tick(1'b0, 32'h0, acc);
    reset = 1'b0;
    pc_r = 0;
    drain();

    pending = 0;
    word = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        word = rand_instr();
        pending = 1;
      end
      tick(pending, word, acc);
      if (acc) pending = 0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
